// File: rtl/seq_round_divider.sv
// seq_round_divider
//   Multi-cycle unsigned divider: S = A / B, optionally rounded to nearest.
//   Rounding rounds up only when remainder > floor(B/2), so ties round down.
//   Uses a restoring radix-2 loop that produces one quotient bit per clock.
//
// Parameters:
//   WIDTH         operand width in bits (>= 2)
//   ROUND_DEFAULT reset value of the latched rounding mode
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   start    operation request; accepted only while idle
//   round_en 1 = round to nearest, 0 = truncate; sampled with the operands
//   A, B     dividend and divisor, unsigned
//   S        result, zero-extended to WIDTH+1; held until the next result
//   flag     divide-by-zero; held with S
//   busy     high from the acceptance edge until the return to idle
//   done     one-cycle pulse; S and flag are valid from this cycle on
//   R_out    final remainder A mod B (only when DIV_REM_OUT_EN is defined)
//
// Optional feature macro: DIV_REM_OUT_EN (adds the R_out port).
module seq_round_divider #(
  parameter int unsigned WIDTH         = 7,
  parameter bit          ROUND_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             round_en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   S,
  output logic             flag,
  output logic             busy,
`ifdef DIV_REM_OUT_EN
  output logic [WIDTH-1:0] R_out,
`endif
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;   // dividend, shifted out MSB first
  logic [WIDTH-1:0] b_q;
  logic             rnd_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_nx;
  logic             q_bit;
  logic             up;
  logic [WIDTH:0]   q_fin;

  // The partial remainder always stays below B, so its low WIDTH bits
  // hold it completely and the shift cannot lose information.
  always_comb begin
    r_sh  = {r[WIDTH-1:0], a_sh[WIDTH-1]};
    q_bit = (r_sh >= {1'b0, b_q});
    r_nx  = q_bit ? (r_sh - {1'b0, b_q}) : r_sh;
    up    = rnd_q && (r > {1'b0, (b_q >> 1)});
    q_fin = {1'b0, q} + {{WIDTH{1'b0}}, up};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_q   <= '0;
      rnd_q <= ROUND_DEFAULT;
      q     <= '0;
      r     <= '0;
      cnt   <= '0;
      S     <= '0;
      flag  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DIV_REM_OUT_EN
      R_out <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_q   <= B;
            rnd_q <= round_en;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b1;
            if (B == '0) begin
              // Divide-by-zero skips the loop and publishes the result
              // at the acceptance edge.
              S     <= '0;
              flag  <= 1'b1;
              done  <= 1'b1;
`ifdef DIV_REM_OUT_EN
              R_out <= '0;
`endif
              state <= DONE;
            end else begin
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          r    <= r_nx;
          q    <= {q[WIDTH-2:0], q_bit};
          a_sh <= {a_sh[WIDTH-2:0], 1'b0};
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ROUND;
        end
        ROUND: begin
          // Outputs are registered on entry to DONE so done, S and flag
          // appear together in the DONE cycle.
          S     <= q_fin;
          flag  <= 1'b0;
          done  <= 1'b1;
`ifdef DIV_REM_OUT_EN
          R_out <= r[WIDTH-1:0];
`endif
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_round_divider.sv
module tb_seq_round_divider;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         round_en;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W:0]   S;
  logic         flag;
  logic         busy;
  logic         done;
`ifdef DIV_REM_OUT_EN
  logic [W-1:0] R_out;
`endif

  seq_round_divider #(.WIDTH(W), .ROUND_DEFAULT(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .round_en (round_en),
    .A        (A),
    .B        (B),
    .S        (S),
    .flag     (flag),
    .busy     (busy),
`ifdef DIV_REM_OUT_EN
    .R_out    (R_out),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;

  typedef struct {
    logic [W:0]   s;
    logic         f;
    logic [W-1:0] r;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scoreboard consumer: each done pulse retires one expected result.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("S", {23'd0, S}, {23'd0, e.s});
        check("flag", {31'd0, flag}, {31'd0, e.f});
`ifdef DIV_REM_OUT_EN
        check("R_out", {25'd0, R_out}, {25'd0, e.r});
`endif
      end
    end
  end

  function automatic exp_t model(input int a, input int b, input bit rnd);
    exp_t e;
    int qq, rr;
    if (b == 0) begin
      e.s = '0; e.f = 1'b1; e.r = '0;
    end else begin
      qq = a / b;
      rr = a % b;
      if (rnd && (rr > b / 2)) qq = qq + 1;
      e.s = (W+1)'(qq); e.f = 1'b0; e.r = W'(rr);
    end
    return e;
  endfunction

  // Issues one operation and waits for its done; poke re-pulses start with
  // different operands while the operation is running.
  task automatic run_op(input int a, input int b, input bit rnd, input bit poke);
    int n;
    int d0;
    bit seen;
    int exp_lat;
    sb.push_back(model(a, b, rnd));
    exp_lat = (b == 0) ? 1 : W + 2;
    @(negedge clk);
    A = W'(a); B = W'(b); round_en = rnd; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    seen = 1'b0;
    check("busy_accept", {31'd0, busy}, 32'd1);
    while (!seen && n < 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (poke && n == 3) begin
          start = 1'b1; A = 7'd99; B = 7'd3; round_en = 1'b0;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    check("latency", seen ? n : 0, exp_lat);
    @(posedge clk); #1;
    check("busy_end", {31'd0, busy}, 32'd0);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; round_en = 1'b1; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_S", {23'd0, S}, 0);
    check("rst_flag", {31'd0, flag}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    reset = 1'b0;

    run_op(100, 7, 1'b1, 1'b0);
    run_op(11, 3, 1'b1, 1'b0);
    run_op(10, 4, 1'b1, 1'b0);
    run_op(127, 1, 1'b1, 1'b0);
    run_op(127, 2, 1'b1, 1'b0);
    run_op(11, 3, 1'b0, 1'b0);
    run_op(0, 5, 1'b0, 1'b0);
    run_op(55, 0, 1'b1, 1'b0);
    run_op(9, 2, 1'b1, 1'b0);
    run_op(50, 5, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_op(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
             1'(($urandom_range(0, 1))), 1'b0);
    end
    run_op(100, 7, 1'b1, 1'b0);

    // Abort mid-operation: reset before the 4th edge after acceptance.
    begin
      int d0;
      @(negedge clk);
      A = 7'd90; B = 7'd4; round_en = 1'b1; start = 1'b1;
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_S", {23'd0, S}, 0);
      check("abort_flag", {31'd0, flag}, 0);
      check("abort_done", {31'd0, done}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
    end

    run_op(20, 6, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
